float_vector_result_collector: RTL

- Sits at the output end of any fixed-latency, non-backpressurable float vector unit that is driven by `trigger` and answers with `result`/`result_valid` (subtract, add, multiply lanes).
- Gates upstream issue with credits, so every result issued has a guaranteed buffer slot.
- Buffers returning result lines in a FIFO and presents them downstream as a ready/valid stream.

---
 rtl/float_vector_pkg.sv | 17 +
 rtl/float_vector_line_fifo.sv | 71 +++++++
 rtl/float_vector_result_collector.sv | 94 +++++++++
 3 files changed

// File: rtl/float_vector_pkg.sv
// Shared constants and width helpers for the float vector result collector.
package float_vector_pkg;

  localparam int unsigned FLOAT_W = 32;

  typedef int unsigned width_t;

  function automatic width_t line_width(input width_t values_per_line);
    return FLOAT_W * values_per_line;
  endfunction

  // One extra bit so a completely full buffer (DEPTH) is representable.
  function automatic width_t count_width(input width_t depth);
    return width_t'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/float_vector_line_fifo.sv
// Synchronous line FIFO with a registered first-word-fall-through head.
// A write into an empty FIFO becomes visible at rd_valid one cycle later.
module float_vector_line_fifo #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_next;
  logic [PW-1:0]    rd_ptr_next;
  logic [PW-1:0]    count_next;
  logic             do_wr;
  logic             do_rd;
  logic [WIDTH-1:0] head_next;

  // Pointer MSBs differ and the indices match only when every slot is used.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_rd       = rd_valid && rd_ready;
  assign do_wr       = wr_en && (!full || do_rd);
  assign wr_ptr_next = wr_ptr + PW'(do_wr);
  assign rd_ptr_next = rd_ptr + PW'(do_rd);
  assign count_next  = wr_ptr_next - rd_ptr_next;

  // The incoming line becomes the head only if nothing older survives the read.
  always_comb begin
    head_next = mem[rd_ptr_next[AW-1:0]];
    if (do_wr && ((count - PW'(do_rd)) == '0)) begin
      head_next = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      rd_valid <= (count_next != '0);
      if (count_next != '0) begin
        rd_data <= head_next;
      end
    end
  end

endmodule

// File: rtl/float_vector_result_collector.sv
// Credit-gated issue and in-order result buffering for a fixed-latency float vector unit.
// Define FLOAT_VECTOR_COLLECTOR_STATS_EN to add issue/stall/high-water statistics outputs.
module float_vector_result_collector
  import float_vector_pkg::*;
#(
  parameter int unsigned VALUES_PER_LINE = 16,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic                                       trigger,
  input  logic [line_width(VALUES_PER_LINE)-1:0]     result,
  input  logic                                       result_valid,
  output logic [line_width(VALUES_PER_LINE)-1:0]     out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [count_width(FIFO_DEPTH)-1:0]         occupancy,
  output logic                                       protocol_error
`ifdef FLOAT_VECTOR_COLLECTOR_STATS_EN
  ,
  output logic [31:0]                                stat_issued,
  output logic [31:0]                                stat_stall_cycles,
  output logic [count_width(FIFO_DEPTH)-1:0]         stat_max_occupancy
`endif
);

  localparam int unsigned LW = line_width(VALUES_PER_LINE);
  localparam int unsigned CW = count_width(FIFO_DEPTH);

  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          retire;
  logic          spurious;
  logic          overflow;

  float_vector_line_fifo #(
    .WIDTH (LW),
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (result_valid),
    .wr_data  (result),
    .rd_ready (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  // Every issued line owns a buffer slot from trigger until it is popped.
  assign occupancy = inflight + fifo_count;
  assign in_ready  = reset && (occupancy < CW'(FIFO_DEPTH));
  assign trigger   = in_valid && in_ready;

  assign retire   = result_valid && (inflight != '0);
  assign spurious = result_valid && (inflight == '0);
  assign overflow = result_valid && fifo_full && !(out_valid && out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight       <= '0;
      protocol_error <= 1'b0;
    end else begin
      inflight       <= inflight + CW'(trigger) - CW'(retire);
      protocol_error <= protocol_error || spurious || overflow;
    end
  end

`ifdef FLOAT_VECTOR_COLLECTOR_STATS_EN
  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued        <= '0;
      stat_stall_cycles  <= '0;
      stat_max_occupancy <= '0;
    end else begin
      if (trigger && (stat_issued != '1)) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if (in_valid && !in_ready && (stat_stall_cycles != '1)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
      if (occupancy > stat_max_occupancy) begin
        stat_max_occupancy <= occupancy;
      end
    end
  end
`endif

endmodule
